// File: rtl/mru_tracker.sv
// mru_tracker: most-recently-used list of the last DEPTH distinct words seen
// on a qualified data stream. Entry 0 is the newest, entry DEPTH-1 the oldest.
//
// Ports:
//   clk_in          - clock, all state on rising edge
//   reset_n_in      - asynchronous active-low reset
//   data_in         - incoming data word
//   data_valid_in   - data_in is sampled only when high
//   flush_in        - synchronous clear of the list and the capture stage
//   out_data        - entry k at [k*DATA_W +: DATA_W], k=0 newest
//   out_valid       - bit k set when entry k holds data (thermometer code)
//   hit_out         - pulse: processed word matched a valid entry
//   hit_idx_out     - pre-update index of the matching entry, held until next hit
//   miss_out        - pulse: processed word was new
//   evict_out       - pulse: a miss pushed a valid word out of the last slot
//   evict_data_out  - evicted word, held until next eviction
//   count_out       - number of valid entries
module mru_tracker #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     data_valid_in,
  input  logic                     flush_in,
  output logic [DEPTH*DATA_W-1:0]  out_data,
  output logic [DEPTH-1:0]         out_valid,
  output logic                     hit_out,
  output logic [IDX_W-1:0]         hit_idx_out,
  output logic                     miss_out,
  output logic                     evict_out,
  output logic [DATA_W-1:0]        evict_data_out,
  output logic [CNT_W-1:0]         count_out
);

  // Capture stage
  logic [DATA_W-1:0] stage_data;
  logic              stage_vld;

  // Next-state values for the registered outputs
  logic [DEPTH*DATA_W-1:0] data_nxt;
  logic [DEPTH-1:0]        valid_nxt;
  logic                    hit_nxt;
  logic [IDX_W-1:0]        hit_idx_nxt;
  logic                    miss_nxt;
  logic                    evict_nxt;
  logic [DATA_W-1:0]       evict_data_nxt;
  logic [CNT_W-1:0]        count_nxt;

  // Update-stage decode
  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] shift;
  logic [IDX_W-1:0] match_idx;
  logic             proc;
  logic             is_hit;
  logic             is_miss;
  logic             pend;

  // Capture stage: flush drops whatever is being captured this cycle
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      stage_data <= '0;
      stage_vld  <= 1'b0;
    end else begin
      stage_data <= data_in;
      stage_vld  <= data_valid_in & ~flush_in;
    end
  end

  // Match against valid entries only; entries are distinct so at most one hits
  always_comb begin
    match     = '0;
    match_idx = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      match[k] = out_valid[k] && (out_data[k*DATA_W +: DATA_W] == stage_data);
      if (match[k]) match_idx = IDX_W'(k);
    end
  end

  assign proc    = stage_vld & ~flush_in;
  assign is_hit  = proc & (|match);
  assign is_miss = proc & ~(|match);

  // Entry k (k>=1) takes entry k-1 on a miss, or on a hit at index >= k
  always_comb begin
    shift = '0;
    pend  = is_miss;
    for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
      pend     = pend | (is_hit & match[k]);
      shift[k] = pend;
    end
  end

  // List update and reporting
  always_comb begin
    data_nxt       = out_data;
    valid_nxt      = out_valid;
    hit_nxt        = 1'b0;
    hit_idx_nxt    = hit_idx_out;
    miss_nxt       = 1'b0;
    evict_nxt      = 1'b0;
    evict_data_nxt = evict_data_out;
    count_nxt      = count_out;

    if (flush_in) begin
      data_nxt  = '0;
      valid_nxt = '0;
      count_nxt = '0;
    end else if (proc) begin
      data_nxt[0 +: DATA_W] = stage_data;
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (shift[k]) data_nxt[k*DATA_W +: DATA_W] = out_data[(k-1)*DATA_W +: DATA_W];
      end
      if (is_hit) begin
        hit_nxt     = 1'b1;
        hit_idx_nxt = match_idx;
      end else begin
        miss_nxt  = 1'b1;
        valid_nxt = {out_valid[DEPTH-2:0], 1'b1};
        if (out_valid[DEPTH-1]) begin
          evict_nxt      = 1'b1;
          evict_data_nxt = out_data[(DEPTH-1)*DATA_W +: DATA_W];
        end else begin
          count_nxt = count_out + CNT_W'(1);
        end
      end
    end
  end

  // Output registers
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      out_data       <= '0;
      out_valid      <= '0;
      hit_out        <= 1'b0;
      hit_idx_out    <= '0;
      miss_out       <= 1'b0;
      evict_out      <= 1'b0;
      evict_data_out <= '0;
      count_out      <= '0;
    end else begin
      out_data       <= data_nxt;
      out_valid      <= valid_nxt;
      hit_out        <= hit_nxt;
      hit_idx_out    <= hit_idx_nxt;
      miss_out       <= miss_nxt;
      evict_out      <= evict_nxt;
      evict_data_out <= evict_data_nxt;
      count_out      <= count_nxt;
    end
  end

endmodule

// File: tb/tb_mru_tracker.sv
// Directed self-checking bench for mru_tracker (DATA_W=8, DEPTH=4).
module tb_mru_tracker;

  logic        clk_in;
  logic        reset_n_in;
  logic [7:0]  data_in;
  logic        data_valid_in;
  logic        flush_in;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic        hit_out;
  logic [1:0]  hit_idx_out;
  logic        miss_out;
  logic        evict_out;
  logic [7:0]  evict_data_out;
  logic [2:0]  count_out;

  int passed = 0;
  int total  = 0;

  mru_tracker #(.DATA_W(8), .DEPTH(4)) dut (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .flush_in      (flush_in),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .hit_out       (hit_out),
    .hit_idx_out   (hit_idx_out),
    .miss_out      (miss_out),
    .evict_out     (evict_out),
    .evict_data_out(evict_data_out),
    .count_out     (count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got %0d/%0d", passed, total);
    $fatal(1);
  end

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    data_in       = w;
    data_valid_in = 1'b1;
    step();
  endtask

  task automatic idle();
    data_valid_in = 1'b0;
    step();
  endtask

  task automatic do_flush();
    flush_in      = 1'b1;
    data_valid_in = 1'b0;
    step();
    flush_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_in    = 1'b0;
    flush_in      = 1'b0;
    data_in       = 8'h00;
    data_valid_in = 1'b1;
    step(); step();
    total++;
    if ({out_data, out_valid, hit_out, hit_idx_out, miss_out, evict_out, evict_data_out, count_out} !== '0)
      $display("FAIL reset_outputs: got data=%h valid=%b h=%b hi=%0d m=%b e=%b ed=%h c=%0d, expected all 0",
               out_data, out_valid, hit_out, hit_idx_out, miss_out, evict_out, evict_data_out, count_out);
    else passed++;
    reset_n_in = 1'b1;
    step();                 // edge 1 captures 0x00
    data_valid_in = 1'b0;
    step();                 // edge 2 applies it
    total++;
    if ({hit_out, miss_out, evict_out} !== 3'b010 || out_valid !== 4'b0001 ||
        out_data !== 32'h0 || count_out !== 3'd1)
      $display("FAIL first_word_zero: got h/m/e=%b%b%b valid=%b data=%h c=%0d, expected 010 0001 00000000 1",
               hit_out, miss_out, evict_out, out_valid, out_data, count_out);
    else passed++;
  endtask

  task automatic test_fill_evict();
    logic [7:0] words [5];
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_flush();
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) push(words[i]); else idle();
      if (i >= 1) begin
        total++;
        if ({hit_out, miss_out, evict_out} !== {2'b01, (i == 5)} ||
            count_out !== ((i >= 4) ? 3'd4 : 3'(i)))
          $display("FAIL fill_word%0d: got h/m/e=%b%b%b c=%0d, expected 01%b c=%0d",
                   i - 1, hit_out, miss_out, evict_out, count_out, (i == 5), (i >= 4) ? 4 : i);
        else passed++;
      end
    end
    total++;
    if (evict_data_out !== 8'h11 || out_data !== 32'h22334455 || out_valid !== 4'b1111)
      $display("FAIL evict_list: got ed=%h data=%h valid=%b, expected 11 22334455 1111",
               evict_data_out, out_data, out_valid);
    else passed++;
  endtask

  task automatic test_move_to_front();
    do_flush();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    push(8'h22);            // applies 0x44
    push(8'h22);            // applies first 0x22
    total++;
    if ({hit_out, miss_out, evict_out} !== 3'b100 || hit_idx_out !== 2'd2 ||
        out_data !== 32'h11334422 || count_out !== 3'd4)
      $display("FAIL mtf_hit2: got h/m/e=%b%b%b idx=%0d data=%h c=%0d, expected 100 2 11334422 4",
               hit_out, miss_out, evict_out, hit_idx_out, out_data, count_out);
    else passed++;
    push(8'h11);            // applies second 0x22
    total++;
    if ({hit_out, miss_out, evict_out} !== 3'b100 || hit_idx_out !== 2'd0 || out_data !== 32'h11334422)
      $display("FAIL mtf_hit0: got h/m/e=%b%b%b idx=%0d data=%h, expected 100 0 11334422",
               hit_out, miss_out, evict_out, hit_idx_out, out_data);
    else passed++;
    idle();                 // applies 0x11, sitting in the last slot
    total++;
    if ({hit_out, miss_out, evict_out} !== 3'b100 || hit_idx_out !== 2'd3 ||
        out_data !== 32'h33442211 || out_valid !== 4'b1111)
      $display("FAIL mtf_hit3: got h/m/e=%b%b%b idx=%0d data=%h valid=%b, expected 100 3 33442211 1111",
               hit_out, miss_out, evict_out, hit_idx_out, out_data, out_valid);
    else passed++;
    idle();
    total++;
    if ({hit_out, miss_out, evict_out} !== 3'b000 || hit_idx_out !== 2'd3)
      $display("FAIL idle_hold: got h/m/e=%b%b%b idx=%0d, expected 000 3",
               hit_out, miss_out, evict_out, hit_idx_out);
    else passed++;
  endtask

  task automatic test_valid_qualifier();
    do_flush();
    push(8'hAA);
    data_in = 8'hBB; data_valid_in = 1'b0; step();   // applies 0xAA
    total++;
    if ({hit_out, miss_out, evict_out} !== 3'b010)
      $display("FAIL vq_aa: got h/m/e=%b%b%b, expected 010", hit_out, miss_out, evict_out);
    else passed++;
    push(8'hCC);            // gap cycle
    total++;
    if ({hit_out, miss_out, evict_out} !== 3'b000 || out_data !== 32'h000000AA)
      $display("FAIL vq_gap: got h/m/e=%b%b%b data=%h, expected 000 000000aa",
               hit_out, miss_out, evict_out, out_data);
    else passed++;
    idle();                 // applies 0xCC
    total++;
    if ({hit_out, miss_out, evict_out} !== 3'b010 || out_data !== 32'h0000AACC ||
        out_valid !== 4'b0011 || count_out !== 3'd2)
      $display("FAIL vq_list: got h/m/e=%b%b%b data=%h valid=%b c=%0d, expected 010 0000aacc 0011 2",
               hit_out, miss_out, evict_out, out_data, out_valid, count_out);
    else passed++;
  endtask

  task automatic test_flush_collision();
    do_flush();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    push(8'h55);            // list full, 0x55 now pending in stage
    flush_in = 1'b1; data_in = 8'h77; data_valid_in = 1'b1;
    step();
    total++;
    if (out_valid !== 4'b0000 || count_out !== 3'd0 || out_data !== 32'h0 ||
        {hit_out, miss_out, evict_out} !== 3'b000)
      $display("FAIL flush_clear: got valid=%b c=%0d data=%h h/m/e=%b%b%b, expected 0000 0 00000000 000",
               out_valid, count_out, out_data, hit_out, miss_out, evict_out);
    else passed++;
    flush_in = 1'b0;
    push(8'h77);            // staged word from flush cycle was dropped
    total++;
    if ({hit_out, miss_out, evict_out} !== 3'b000 || out_valid !== 4'b0000)
      $display("FAIL flush_drop: got h/m/e=%b%b%b valid=%b, expected 000 0000",
               hit_out, miss_out, evict_out, out_valid);
    else passed++;
    push(8'h00);            // applies 0x77
    total++;
    if ({hit_out, miss_out, evict_out} !== 3'b010 || out_data !== 32'h00000077 ||
        out_valid !== 4'b0001 || count_out !== 3'd1)
      $display("FAIL flush_after: got h/m/e=%b%b%b data=%h valid=%b c=%0d, expected 010 00000077 0001 1",
               hit_out, miss_out, evict_out, out_data, out_valid, count_out);
    else passed++;
    push(8'h00);            // applies 0x00: invalid zero slots must not match
    total++;
    if ({hit_out, miss_out} !== 2'b01 || out_data !== 32'h00007700 || count_out !== 3'd2)
      $display("FAIL zero_miss: got h/m=%b%b data=%h c=%0d, expected 01 00007700 2",
               hit_out, miss_out, out_data, count_out);
    else passed++;
    idle();                 // second 0x00 hits at index 0
    total++;
    if ({hit_out, miss_out} !== 2'b10 || hit_idx_out !== 2'd0 || out_data !== 32'h00007700)
      $display("FAIL zero_hit: got h/m=%b%b idx=%0d data=%h, expected 10 0 00007700",
               hit_out, miss_out, hit_idx_out, out_data);
    else passed++;
  endtask

  task automatic test_async_reset();
    push(8'h12); push(8'h34); push(8'h56);
    #3;
    reset_n_in = 1'b0;
    #1;
    total++;
    if ({out_data, out_valid, hit_out, hit_idx_out, miss_out, evict_out, evict_data_out, count_out} !== '0)
      $display("FAIL async_reset: got data=%h valid=%b h=%b hi=%0d m=%b e=%b ed=%h c=%0d, expected all 0",
               out_data, out_valid, hit_out, hit_idx_out, miss_out, evict_out, evict_data_out, count_out);
    else passed++;
    data_valid_in = 1'b0;
    step();
    reset_n_in = 1'b1;
    push(8'h12);
    idle();
    total++;
    if ({hit_out, miss_out, evict_out} !== 3'b010 || out_data !== 32'h00000012 ||
        out_valid !== 4'b0001 || count_out !== 3'd1)
      $display("FAIL post_reset: got h/m/e=%b%b%b data=%h valid=%b c=%0d, expected 010 00000012 0001 1",
               hit_out, miss_out, evict_out, out_data, out_valid, count_out);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_evict();
    test_move_to_front();
    test_valid_qualifier();
    test_flush_collision();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mru_tracker.md
Name: mru_tracker

Overview:
- Parametrised most-recently-used tracker. Keeps the last DEPTH distinct values seen on a data stream, ordered newest (entry 0) to oldest (entry DEPTH-1).
- Successor to the fixed 4-entry, 8-bit tracker. Adds:
  - generic width and depth;
  - an input valid qualifier;
  - hit/miss/evict reporting;
  - occupancy count;
  - synchronous flush.
- Invalid entries never match incoming data.
- Sits after the input-capture stage, feeding downstream lookup/statistics logic.

Parameters:
- DATA_W, 8, width of one data word (>=1).
- DEPTH, 4, number of tracked entries (>=2).
- IDX_W, $clog2(DEPTH), width of the hit index (localparam).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (localparam).

Ports:
- clk_in, input, 1, single clock; all logic on rising edge.
- reset_n_in, input, 1, asynchronous active-low reset.
- data_in, input, DATA_W, incoming data word.
- data_valid_in, input, 1, data_in is sampled only when 1.
- flush_in, input, 1, synchronous clear of the list and the input stage.
- out_data, output, DEPTH*DATA_W, entry k at bits [k*DATA_W +: DATA_W]; k=0 is newest.
- out_valid, output, DEPTH, bit k set = entry k holds data.
- hit_out, output, 1, one-cycle pulse: the last processed word matched a valid entry.
- hit_idx_out, output, IDX_W, index of the matching entry (before the update); held until the next hit.
- miss_out, output, 1, one-cycle pulse: the last processed word was new.
- evict_out, output, 1, one-cycle pulse: a miss pushed a valid entry out of slot DEPTH-1.
- evict_data_out, output, DATA_W, the evicted word; held until the next eviction.
- count_out, output, CNT_W, popcount of out_valid.

Behaviour:
- Reset (async, reset_n_in=0): all outputs 0, stage register 0, stage valid 0. Release is synchronous to clk_in.
- Stage 1 (capture): on each edge, stage_data <= data_in and stage_vld <= data_valid_in. When flush_in=1, stage_vld <= 0 instead.
- Stage 2 (update): on each edge with stage_vld=1 and flush_in=0, compare stage_data against every entry k with out_valid[k]=1.
  - Entries are distinct by construction, so at most one match.
- Latency: a word presented at edge t is applied to the list and reflected in hit/miss/evict at edge t+1. Outputs are visible after edge t+1. Throughput is one word per clock.
- Hit at index k:
  - entry 0 <= stage_data; entries 1..k <= old entries 0..k-1; entries k+1..DEPTH-1 unchanged.
  - out_valid unchanged.
  - hit_out=1, hit_idx_out=k.
  - Hit at k=0 leaves the list unchanged but still pulses hit_out.
- Miss:
  - entry 0 <= stage_data; entries 1..DEPTH-1 <= old entries 0..DEPTH-2.
  - out_valid <= {old out_valid[DEPTH-2:0], 1}.
  - miss_out=1.
  - If old out_valid[DEPTH-1]=1: evict_out=1, evict_data_out <= old entry DEPTH-1.
- Idle (stage_vld=0): list unchanged; hit_out, miss_out and evict_out are 0.
- Flush (flush_in=1):
  - next edge clears out_valid, all entries and count_out to 0, and drops the staged word;
  - pulse outputs 0 that cycle;
  - data_valid_in in the same cycle is dropped;
  - flush has priority over a pending stage-2 update.
- A word arriving the cycle after flush deasserts is processed normally against the empty list, so it misses.
- Back-to-back identical words: the second hits at index 0.
- Zero is a legal data value; it matches only valid entries holding 0.
- out_valid is always contiguous from bit 0 (thermometer code).
- count_out is updated in the same edge as out_valid.

Test Plan:
- Reset and empty list, DEPTH=4, DATA_W=8: with reset_n_in low, drive data_in=0x00 with data_valid_in=1 -> all outputs 0. Release reset; first word 0x00 at edge 1 -> miss_out=1 at edge 2, out_valid=4'b0001, entry0=0x00, count_out=1.
- Fill and evict: stream 0x11, 0x22, 0x33, 0x44, 0x55 -> four misses with no evict. Fifth word gives miss_out=1, evict_out=1, evict_data_out=0x11. List becomes 55,44,33,22; count_out=4.
- Move-to-front: with list 44,33,22,11, send 0x22 -> hit_out=1, hit_idx_out=2, list becomes 22,44,33,11, no evict. Then send 0x22 -> hit_idx_out=0, list unchanged.
- Valid qualifier: toggle data_valid_in 1,0,1 with 0xAA, 0xBB, 0xCC -> only 0xAA and 0xCC are processed; no pulse in the gap cycle; list is CC,AA.
- Flush collision: with list full, assert flush_in together with data_valid_in=1 and data_in=0x77 -> next edge gives out_valid=0, count_out=0, no pulses. The following 0x77 misses into entry0.
- Async reset mid-stream: pull reset_n_in low between edges during traffic -> outputs clear immediately, without waiting for a clock edge. First word after release misses.
